// File: rtl/mant_div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_fma_pkg (package)
//  Purpose  : Shared constants for the FMA/divide mantissa datapath: divider
//             FSM state encodings, default mantissa width and the helper that
//             sizes the iteration counter.
//  Contents : MANT_WIDTH_DEFAULT, ST_IDLE/ST_RUN/ST_DONE, cnt_width()
//  Revision : 1.0 - initial release
// ============================================================================
package fp_fma_pkg;

   // Mantissa width including the hidden bit (single precision).
   localparam int MANT_WIDTH_DEFAULT = 24;

   // Divider FSM state encodings.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // Iteration counter width: it must hold WIDTH-1, so clog2(WIDTH) bits.
   // Never returns less than 1 so the counter is always a legal vector.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage : fp_fma_pkg
`default_nettype wire

// File: rtl/mant_div_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface : mant_div_seq_if
//  Purpose   : Request/response bundle of the sequential mantissa divider.
//  Signals   : start, dividend, divisor      (requester -> divider)
//              busy, done, quotient, remainder, div_by_zero, sticky
//                                            (divider -> requester)
//  Modports  : master - requester side, slave - divider side
//  Revision  : 1.0 - initial release
// ============================================================================
interface mant_div_seq_if
   import fp_fma_pkg::*;
#(
   parameter int WIDTH = MANT_WIDTH_DEFAULT
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             sticky;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, sticky
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, sticky
   );

endinterface : mant_div_seq_if
`default_nettype wire

// File: rtl/mant_div_seq_fullsub.sv
`default_nettype none
// ============================================================================
//  Module   : fullSubtractor
//  Purpose  : Single-bit full subtractor, d = a - b - b_in, borrow on b_out.
//             Borrow-side counterpart of the full adder cell; chained into a
//             ripple by the divider's trial subtract.
//  Ports    : a, b, b_in (in)  /  b_out, d (out)
//  Revision : 1.0 - initial release
// ============================================================================
module fullSubtractor (
   input  wire logic a,
   input  wire logic b,
   input  wire logic b_in,
   output logic      b_out,
   output logic      d
);

   assign d     = a ^ b ^ b_in;
   // Borrow when a < b, or when a == b and a borrow is already pending.
   assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule : fullSubtractor
`default_nettype wire

// File: rtl/mant_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mant_div_seq
//  Purpose  : Sequential restoring divider for unsigned mantissas, one
//             quotient bit per clock. Returns quotient, remainder, a
//             divide-by-zero flag and an optional sticky bit.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-high reset
//             div_if     - mant_div_seq_if.slave (start/dividend/divisor in;
//                          busy/done/quotient/remainder/div_by_zero/sticky out)
//  Config   : MANT_DIV_STICKY_EN - when defined, sticky is the registered
//             OR-reduction of the final remainder; otherwise tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mant_div_seq
   import fp_fma_pkg::*;
#(
   parameter int WIDTH = MANT_WIDTH_DEFAULT
) (
   input  wire logic     clk,
   input  wire logic     rst,
   mant_div_seq_if.slave div_if
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   // Partial remainder P. Its top bit is always 0 after the restore step,
   // so only the low WIDTH bits are stored.
   logic [WIDTH-1:0] p_q,     p_d;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB;
   // after WIDTH iterations this register holds the full quotient.
   logic [WIDTH-1:0] dq_q,    dq_d;
   logic [WIDTH-1:0] dvs_q,   dvs_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic             dbz_q;

   // Result load strobe and values, written on the edge entering DONE.
   logic             res_ld;
   logic [WIDTH-1:0] res_quo;
   logic [WIDTH-1:0] res_rem;
   logic             res_dbz;

   // ------------------------------------------------------------------
   // Trial subtract: T = {P, next dividend bit} - {0, divisor}
   // ------------------------------------------------------------------
   logic [WIDTH:0]   p_sh;
   logic [WIDTH:0]   sub_b;
   logic [WIDTH:0]   diff;
   logic [WIDTH+1:0] brw;
   logic             bout;
   logic [WIDTH-1:0] p_new;
   logic [WIDTH-1:0] dq_next;
   logic             diff_msb_unused;

   assign p_sh   = {p_q, dq_q[WIDTH-1]};
   assign sub_b  = {1'b0, dvs_q};
   assign brw[0] = 1'b0;

   generate
      for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
         fullSubtractor u_fs (
            .a     (p_sh[gi]),
            .b     (sub_b[gi]),
            .b_in  (brw[gi]),
            .b_out (brw[gi+1]),
            .d     (diff[gi])
         );
      end
   endgenerate

   assign bout = brw[WIDTH+1];

   // When no borrow occurs the shifted P was below 2*divisor, so the
   // difference fits in WIDTH bits; when a borrow occurs P was restored and
   // is below the divisor. Either way the top bit of the result is 0.
   assign p_new           = bout ? p_sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign diff_msb_unused = diff[WIDTH];
   assign dq_next         = {dq_q[WIDTH-2:0], ~bout};

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      dq_d    = dq_q;
      dvs_d   = dvs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      res_ld  = 1'b0;
      res_quo = '0;
      res_rem = '0;
      res_dbz = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (div_if.start) begin
               dvs_d  = div_if.divisor;
               dq_d   = div_if.dividend;
               p_d    = '0;
               cnt_d  = CNT_LOAD;
               busy_d = 1'b1;
               if (div_if.divisor == '0) begin
                  // Divide by zero completes without any iterations.
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  res_ld  = 1'b1;
                  res_quo = '1;
                  res_rem = div_if.dividend;
                  res_dbz = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            p_d  = p_new;
            dq_d = dq_next;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               res_ld  = 1'b1;
               res_quo = dq_next;
               res_rem = p_new;
               res_dbz = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         dq_q    <= '0;
         dvs_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         dq_q    <= dq_d;
         dvs_q   <= dvs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         dbz_q <= 1'b0;
      end else if (res_ld) begin
         quo_q <= res_quo;
         rem_q <= res_rem;
         dbz_q <= res_dbz;
      end
   end

`ifdef MANT_DIV_STICKY_EN
   logic sticky_q;

   // Registered alongside the remainder; on divide by zero the remainder is
   // the dividend, so this reports a non-zero dividend.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else if (res_ld) begin
         sticky_q <= |res_rem;
      end
   end

   assign div_if.sticky = sticky_q;
`else
   assign div_if.sticky = 1'b0;
`endif

   assign div_if.busy        = busy_q;
   assign div_if.done        = done_q;
   assign div_if.quotient    = quo_q;
   assign div_if.remainder   = rem_q;
   assign div_if.div_by_zero = dbz_q;

endmodule : mant_div_seq
`default_nettype wire
